mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RV32 pipeline, between the execute stage and write-back. It takes the EX/MEM entry (control, destination register, ALU result, store data, PC+4) and performs word-aligned loads and stores on a ready-handshaked data-memory port. It stalls upstream while an access is outstanding and times out dead accesses. It also selects the write-back value and registers it into the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT, 15: maximum ACCESS cycles without dmem_ready before the access is aborted (legal range 1–255).

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  EX/MEM entry valid.
- ctrl_mem  in  5  [4] mem_read, [3] mem_write, [2] reg_write, [1:0] wb_sel (00 ALU, 01 load data, 10 PC+4, 11 reserved).
- rd_mem  in  5  destination register.
- alu_result  in  32  ALU result / effective address.
- write_data1  in  32  store data.
- pc4_mem  in  32  PC+4 of the instruction.
- stall  out  1  upstream must hold its EX/MEM register while high.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word address (bits [1:0] always 0).
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  access complete this cycle; dmem_rdata valid when loading.
- dmem_rdata  in  32  load data.
- valid_wb  out  1  MEM/WB entry valid.
- reg_write_wb  out  1  write-back enable.
- rd_wb  out  5  destination register.
- wb_data  out  32  write-back value.
- mem_err  out  1  entry in MEM/WB ended in error (misaligned, illegal ctrl, or timeout).

## Operation
- FSM states: IDLE and ACCESS.
- Memory op is defined as valid_in & (mem_read ^ mem_write).
- In IDLE:
  - Aligned memory op (alu_result[1:0] == 0): latch address, we, store data, rd, ctrl and pc4; go to ACCESS. stall = 1 combinationally this cycle. MEM/WB loads a bubble (valid_wb = 0).
  - Misaligned memory op, or mem_read & mem_write both set: no bus access. MEM/WB loads valid_wb = 1, mem_err = 1, reg_write_wb = 0. No stall.
  - Non-memory valid entry: MEM/WB loads directly. wb_data selected by wb_sel. No stall.
  - valid_in = 0: bubble.
- In ACCESS:
  - dmem_req = 1; dmem_addr, dmem_we and dmem_wdata come from latched values and are stable until completion.
  - On dmem_ready: MEM/WB loads the latched entry. wb_data = dmem_rdata if wb_sel = 01. stall = 0 this cycle. Return to IDLE.
  - Without ready: stall = 1, timeout counter increments.
  - Counter at TIMEOUT-1 with no ready: abort. MEM/WB loads valid_wb = 1, mem_err = 1, reg_write_wb = 0. stall = 0. Return to IDLE.
- Write-back rules:
  - reg_write_wb = reg_write & valid & ~err & (rd != 0).
  - wb_sel 11 gives wb_data = 0.
- Counter clears on every entry to ACCESS.

## Timing
- Reset: state IDLE, counter 0. stall, dmem_req, dmem_we, valid_wb, reg_write_wb and mem_err are 0. dmem_addr, dmem_wdata, rd_wb and wb_data are 0.
- Reset asserted mid-ACCESS: next edge returns to IDLE with dmem_req = 0. The access is abandoned and no MEM/WB entry is produced.
- Non-memory entry presented in cycle N appears on the MEM/WB outputs in N+1.
- Memory entry presented in cycle N:
  - dmem_req rises in N+1.
  - If ready arrives in cycle N+k (k ≥ 1): result is valid in N+k+1, and stall is high for cycles N .. N+k-1.
- Timeout: dmem_req is high for exactly TIMEOUT cycles; the error entry is valid the cycle after the last request cycle.
- dmem_ready outside ACCESS is ignored.
- A new entry is accepted in the same cycle the previous access completes only if upstream has advanced. The completing cycle has stall = 0, so the next entry is sampled in IDLE on the following cycle.

## Structure
- Shared package pipeline_pkg holds:
  - ctrl_mem bit positions (MEM_RD, MEM_WR, REG_WR, WB_SEL msb/lsb);
  - wb_sel encodings WB_ALU, WB_MEM, WB_PC4;
  - the mem_state_t enum (IDLE, ACCESS).
- One sub-module, dmem_timer: clear/enable counter with terminal-count flag, parameterised by TIMEOUT.
- The FSM, bus drive and MEM/WB register stay in mem_stage.

## Test plan
- ALU op, ctrl = 0_0_1_00, rd = 5, alu_result = 0x1234 -> next cycle: valid_wb = 1, reg_write_wb = 1, rd_wb = 5, wb_data = 0x1234, stall never high.
- Load from 0x100, memory returns 0xDEADBEEF with 2 wait cycles -> dmem_req high 3 cycles with addr 0x100 and we = 0; stall high 3 cycles; then wb_data = 0xDEADBEEF, reg_write_wb = 1.
- Store of 0xCAFEF00D to 0x204, ready on first request cycle -> dmem_we = 1, wdata = 0xCAFEF00D; stall high 1 cycle; MEM/WB valid with reg_write_wb = 0.
- Load at 0x102 (misaligned) -> dmem_req stays 0; next cycle valid_wb = 1, mem_err = 1, reg_write_wb = 0.
- Load with dmem_ready never asserted, TIMEOUT = 15 -> dmem_req high exactly 15 cycles, then mem_err = 1, reg_write_wb = 0, FSM back in IDLE.
- Reset pulsed during the 3rd wait cycle of a load -> dmem_req = 0 after the edge; no valid_wb; the next ALU op passes through normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: EX/MEM control layout, write-back select encodings,
// the memory-stage FSM states and the latched memory-access entry.
package pipeline_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 5;

    // ctrl_mem bit positions
    localparam int unsigned MEM_RD     = 4;
    localparam int unsigned MEM_WR     = 3;
    localparam int unsigned REG_WR     = 2;
    localparam int unsigned WB_SEL_MSB = 1;
    localparam int unsigned WB_SEL_LSB = 0;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Entry held for the duration of an outstanding data-memory access
    typedef struct packed {
        logic              we;
        logic              reg_wr;
        logic [1:0]        wb_sel;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   pc4;
    } mem_entry_t;

    // Write-back value mux; the reserved encoding yields zero
    function automatic logic [XLEN-1:0] wb_select(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] pc4
    );
        logic [XLEN-1:0] res;
        case (sel)
            WB_ALU:  res = alu;
            WB_MEM:  res = mem;
            WB_PC4:  res = pc4;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Clear/enable cycle counter with terminal-count flag at TIMEOUT-1,
// used to bound how long a data-memory access may wait for ready.
module dmem_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign terminal_c = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: issues word loads/stores on a ready-handshaked port,
// stalls upstream while busy, aborts dead accesses and registers the MEM/WB entry.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [CTRL_W-1:0]   ctrl_mem,
    input  logic [REG_AW-1:0]   rd_mem,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     write_data1,
    input  logic [XLEN-1:0]     pc4_mem,
    output logic                stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_ready,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                valid_wb,
    output logic                reg_write_wb,
    output logic [REG_AW-1:0]   rd_wb,
    output logic [XLEN-1:0]     wb_data,
    output logic                mem_err
);

    mem_state_t state_q, state_d;
    mem_entry_t ent_q;

    logic latch_en;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc_c;

    logic              wb_valid_d;
    logic              wb_err_d;
    logic              wb_rw_d;
    logic [REG_AW-1:0] wb_rd_d;
    logic [XLEN-1:0]   wb_data_d;

    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr_in;
    logic [1:0] sel_in;
    logic       mem_op;
    logic       bad_op;

    // EX/MEM entry decode
    assign mem_rd    = ctrl_mem[MEM_RD];
    assign mem_wr    = ctrl_mem[MEM_WR];
    assign reg_wr_in = ctrl_mem[REG_WR];
    assign sel_in    = ctrl_mem[WB_SEL_MSB:WB_SEL_LSB];
    assign mem_op    = valid_in & (mem_rd ^ mem_wr);
    assign bad_op    = (valid_in & mem_rd & mem_wr) | (mem_op & (alu_result[1:0] != 2'b00));

    dmem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (tmr_clr),
        .enable     (tmr_en),
        .terminal_c (tmr_tc_c)
    );

    // Next-state, stall and MEM/WB next-value logic
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        latch_en   = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        wb_valid_d = 1'b0;
        wb_err_d   = 1'b0;
        wb_rw_d    = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (bad_op) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    wb_rd_d    = rd_mem;
                end else if (mem_op) begin
                    state_d  = ACCESS;
                    stall    = 1'b1;
                    latch_en = 1'b1;
                    tmr_clr  = 1'b1;
                end else if (valid_in) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_mem;
                    wb_rw_d    = reg_wr_in & (rd_mem != '0);
                    wb_data_d  = wb_select(sel_in, alu_result, '0, pc4_mem);
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = ent_q.rd;
                    wb_rw_d    = ent_q.reg_wr & (ent_q.rd != '0);
                    wb_data_d  = wb_select(ent_q.wb_sel, ent_q.addr, dmem_rdata, ent_q.pc4);
                end else if (tmr_tc_c) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    wb_rd_d    = ent_q.rd;
                end else begin
                    stall  = 1'b1;
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, access latch and MEM/WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ent_q        <= '0;
            valid_wb     <= 1'b0;
            mem_err      <= 1'b0;
            reg_write_wb <= 1'b0;
            rd_wb        <= '0;
            wb_data      <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                ent_q.we     <= mem_wr;
                ent_q.reg_wr <= reg_wr_in;
                ent_q.wb_sel <= sel_in;
                ent_q.rd     <= rd_mem;
                ent_q.addr   <= alu_result;
                ent_q.wdata  <= write_data1;
                ent_q.pc4    <= pc4_mem;
            end
            valid_wb     <= wb_valid_d;
            mem_err      <= wb_err_d;
            reg_write_wb <= wb_rw_d;
            rd_wb        <= wb_rd_d;
            wb_data      <= wb_data_d;
        end
    end

    // Bus drive straight from the latched entry
    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = ent_q.we;
    assign dmem_addr  = ent_q.addr;
    assign dmem_wdata = ent_q.wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage; a transaction-level model predicts
// bus activity, stall length and the resulting MEM/WB entry of each instruction.
module tb_mem_stage;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [4:0]  ctrl_mem;
    logic [4:0]  rd_mem;
    logic [31:0] alu_result;
    logic [31:0] write_data1;
    logic [31:0] pc4_mem;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        valid_wb;
    logic        reg_write_wb;
    logic [4:0]  rd_wb;
    logic [31:0] wb_data;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ctrl_mem     (ctrl_mem),
        .rd_mem       (rd_mem),
        .alu_result   (alu_result),
        .write_data1  (write_data1),
        .pc4_mem      (pc4_mem),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .valid_wb     (valid_wb),
        .reg_write_wb (reg_write_wb),
        .rd_wb        (rd_wb),
        .wb_data      (wb_data),
        .mem_err      (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction; w = wait cycles before ready (-1: memory never answers)
    task automatic run_entry(input logic [4:0] ctrl, input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [31:0] pc4, input int w);
        logic        mr, mw, rw, is_mem, bad, exp_err, exp_rw;
        logic [1:0]  sel;
        logic [31:0] rdata, exp_data;
        int          req_exp, req_seen, stall_seen, cyc;
        bit          done;
        mr = ctrl[4]; mw = ctrl[3]; rw = ctrl[2]; sel = ctrl[1:0];
        is_mem = mr ^ mw;
        bad = (mr & mw) | (is_mem & (alu[1:0] != 2'b00));
        rdata = $urandom;
        if (bad) begin
            req_exp = 0; exp_err = 1'b1;
        end else if (is_mem) begin
            exp_err = (w < 0) || (w + 1 > int'(TO));
            req_exp = exp_err ? int'(TO) : w + 1;
        end else begin
            req_exp = 0; exp_err = 1'b0;
        end
        case (sel)
            2'b00:   exp_data = alu;
            2'b01:   exp_data = rdata;
            2'b10:   exp_data = pc4;
            default: exp_data = 32'h0;
        endcase
        exp_rw = rw & ~exp_err & (rd != 5'd0);

        valid_in = 1'b1; ctrl_mem = ctrl; rd_mem = rd;
        alu_result = alu; write_data1 = wd; pc4_mem = pc4;
        req_seen = 0; stall_seen = 0; cyc = 0; done = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (dmem_req) begin
                req_seen++;
                check("dmem_addr", dmem_addr, alu);
                check("dmem_we", 32'(dmem_we), 32'(mw));
                if (mw) check("dmem_wdata", dmem_wdata, wd);
                if (w >= 0 && req_seen == w + 1) begin
                    dmem_ready = 1'b1; dmem_rdata = rdata;
                end else begin
                    dmem_ready = 1'b0; dmem_rdata = $urandom;
                end
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            #1;
            if (stall) stall_seen++;
            done = !stall;
            @(posedge clk); #1;
            cyc++;
        end
        valid_in = 1'b0; dmem_ready = 1'b0;
        check("completed", 32'(done), 32'd1);
        check("req_cycles", 32'(req_seen), 32'(req_exp));
        check("stall_cycles", 32'(stall_seen), 32'(req_exp));
        check("req_after", 32'(dmem_req), 32'd0);
        check("valid_wb", 32'(valid_wb), 32'd1);
        check("mem_err", 32'(mem_err), 32'(exp_err));
        check("reg_write_wb", 32'(reg_write_wb), 32'(exp_rw));
        if (!exp_err) begin
            check("rd_wb", 32'(rd_wb), 32'(rd));
            check("wb_data", wb_data, exp_data);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  c;
        int          kind, w;

        reset = 1'b1; valid_in = 1'b0; ctrl_mem = '0; rd_mem = '0;
        alu_result = '0; write_data1 = '0; pc4_mem = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_valid", 32'(valid_wb), 32'd0);
        check("rst_rw", 32'(reg_write_wb), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_rd", 32'(rd_wb), 32'd0);
        check("rst_data", wb_data, 32'd0);
        reset = 1'b0;

        // Directed cases
        run_entry(5'b00100, 5'd5, 32'h1234, 32'h0, 32'h40, 0);
        run_entry(5'b10101, 5'd9, 32'h100, 32'h0, 32'h44, 2);
        run_entry(5'b01000, 5'd3, 32'h204, 32'hCAFEF00D, 32'h48, 0);
        run_entry(5'b10101, 5'd9, 32'h102, 32'h0, 32'h4C, 0);
        run_entry(5'b10101, 5'd4, 32'h300, 32'h0, 32'h50, -1);
        run_entry(5'b11101, 5'd4, 32'h300, 32'h0, 32'h54, 0);
        run_entry(5'b00110, 5'd0, 32'h55, 32'h0, 32'h58, 0);
        run_entry(5'b00111, 5'd6, 32'h55, 32'h0, 32'h5C, 0);
        run_entry(5'b00110, 5'd31, 32'h55, 32'h0, 32'h60, 0);

        // Bubble stays a bubble
        @(posedge clk); #1;
        check("bubble_valid", 32'(valid_wb), 32'd0);

        // Reset during the third wait cycle of a load abandons it
        valid_in = 1'b1; ctrl_mem = 5'b10101; rd_mem = 5'd7;
        alu_result = 32'h400; write_data1 = 32'h0; pc4_mem = 32'h64;
        dmem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_req_before", 32'(dmem_req), 32'd1);
        reset = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_valid", 32'(valid_wb), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        run_entry(5'b00100, 5'd12, 32'hA5A5_0001, 32'h0, 32'h68, 0);

        // Randomized instruction mix
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            a = $urandom;
            w = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
            c = 5'($urandom);
            if (kind <= 2) begin
                c[4:3] = 2'b00;
                if (c[1:0] == 2'b01) c[1:0] = 2'b00;
            end else if (kind <= 5) begin
                c[4:3] = 2'b10; a[1:0] = 2'b00;
            end else if (kind <= 7) begin
                c[4:3] = 2'b01; a[1:0] = 2'b00;
            end else if (kind == 8) begin
                c[4:3] = 2'b10;
                if (a[1:0] == 2'b00) a[0] = 1'b1;
            end else begin
                c[4:3] = 2'b11;
            end
            run_entry(c, 5'($urandom), a, $urandom, $urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
